// File: rtl/uart_pkg.sv
// Shared UART definitions: debouncer FSM encodings and a counter-width helper.
package uart_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } deb_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain for bringing an asynchronous input into the clk domain.
module sync_chain #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // shift register, no logic between stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{INIT}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes an asynchronous level and accepts a new value only after
// STABLE_CNT consecutive agreeing samples; emits registered edge pulses.
module debounce_sync
    import uart_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   STABLE_CNT  = 16,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW        = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);

    logic          w_s;
    deb_state_e    r_state;
    deb_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_toggle;
    logic          r_dout;
    logic          r_rise;
    logic          r_fall;
    logic          r_busy;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_s)
    );

    // next-state, counter and toggle decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_toggle    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_s != r_dout) begin
                    if (STABLE_CNT == 1) begin
                        w_toggle  = 1'b1;
                        w_cnt_nxt = CNT_ZERO;
                    end else begin
                        w_state_nxt = ST_QUALIFY;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
            end
            ST_QUALIFY: begin
                if (w_s == r_dout) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_toggle    = 1'b1;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // state, counter and registered outputs; pulses land with the new dout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STABLE;
            r_cnt   <= CNT_ZERO;
            r_dout  <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= r_dout ^ w_toggle;
            r_rise  <= w_toggle & ~r_dout;
            r_fall  <= w_toggle & r_dout;
            r_busy  <= (w_state_nxt == ST_QUALIFY);
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: segment table on the default instance, plus a
// hand-written toggle sequence on a STABLE_CNT=1 instance.
module tb_debounce_sync;

    typedef struct {
        logic rst;
        logic din;
        int   len;
        logic e_dout;
        logic e_rise;
        logic e_fall;
        logic e_busy;
    } seg_t;

    typedef struct {
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic dout, rise, fall, busy;
    logic din1;
    logic dout1, rise1, fall1, busy1;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    seg_t segs [24];
    logic hist [0:40];

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CNT(16), .RESET_LEVEL(1'b1)) u_dut (
        .clk (clk), .rst (rst), .din (din),
        .dout (dout), .rise (rise), .fall (fall), .busy (busy)
    );

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CNT(1), .RESET_LEVEL(1'b1)) u_dut1 (
        .clk (clk), .rst (rst), .din (din1),
        .dout (dout1), .rise (rise1), .fall (fall1), .busy (busy1)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic d, input logic r,
                             input logic f, input logic b, input exp_t e);
        check_bit({tag, "_dout"}, d, e.dout);
        check_bit({tag, "_rise"}, r, e.rise);
        check_bit({tag, "_fall"}, f, e.fall);
        check_bit({tag, "_busy"}, b, e.busy);
    endtask

    initial begin
        exp_t e;
        logic v;

        // Hand-computed from the latency rule: edge 1 captures din, dout
        // changes on edge 18, busy covers edges 3..17.
        segs = '{
            // reset, then idle-high for 50 cycles
            '{1'b1, 1'b1,  3, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 50, 1'b1, 1'b0, 1'b0, 1'b0},
            // 1->0 held: fall on edge 18
            '{1'b0, 1'b0,  2, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0, 1'b0},
            // 0->1 held: rise on edge 18
            '{1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0},
            // 10-cycle low glitch: busy edges 3..12, rejected
            '{1'b0, 1'b0,  2, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0,  8, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1,  2, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0},
            // low for 8 cycles, then reset mid-qualify
            '{1'b0, 1'b0,  2, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0,  6, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b0,  2, 1'b1, 1'b0, 1'b0, 1'b0},
            // release with din still low: no pulse, then fall on edge 18
            '{1'b0, 1'b0,  2, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 1'b0,  5, 1'b0, 1'b0, 1'b0, 1'b0},
            // return high to end
            '{1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0}
        };

        rst  = 1'b1;
        din  = 1'b1;
        din1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < segs[i].len; c++) begin
                rst = segs[i].rst;
                din = segs[i].din;
                sb.push_back('{segs[i].e_dout, segs[i].e_rise, segs[i].e_fall, segs[i].e_busy});
                if (segs[i].rst) begin
                    #1;
                    check_bit($sformatf("seg%0d_c%0d_rst_imm_busy", i, c), busy, 1'b0);
                    check_bit($sformatf("seg%0d_c%0d_rst_imm_dout", i, c), dout, 1'b1);
                end
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check_out($sformatf("seg%0d_c%0d", i, c), dout, rise, fall, busy, e);
            end
        end

        // STABLE_CNT=1: din toggles every 3 cycles, dout follows 3 edges
        // after the driving slot (captured edge k, dout on edge k+2).
        for (int k = 0; k <= 40; k++) hist[k] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            v = (((k - 1) / 3) % 2) != 0;
            hist[k + 2] = v;
            din1 = v;
            sb.push_back('{hist[k], hist[k] & ~hist[k - 1], ~hist[k] & hist[k - 1], 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_out($sformatf("cnt1_k%0d", k), dout1, rise1, fall1, busy1, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count; legal values are 2 or more.
REQ-002 SHALL have parameter STABLE_CNT, default 16: consecutive agreeing samples required to accept a new level; legal values are 1 or more.
REQ-003 SHALL have parameter RESET_LEVEL, default 1'b1: output level during reset (UART idle-high).
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port din, input, 1 bit: asynchronous raw input (RX line or button); no timing relation to clk.
REQ-007 SHALL have port dout, output, 1 bit: synchronized, filtered level.
REQ-008 SHALL have port rise, output, 1 bit: one-cycle pulse when dout goes 0->1.
REQ-009 SHALL have port fall, output, 1 bit: one-cycle pulse when dout goes 1->0.
REQ-010 SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-011 SHALL pass din through a SYNC_STAGES-deep flop chain; the last stage is sample s; no logic between stages.
REQ-012 SHALL implement a two-state FSM: STABLE and QUALIFY.
REQ-013 In STABLE with s == dout, SHALL hold state, with counter at 0 and busy low.
REQ-014 In STABLE with s != dout, SHALL go to QUALIFY and set counter to 1, or, if STABLE_CNT == 1, SHALL toggle dout immediately and stay in STABLE.
REQ-015 In QUALIFY with s == dout, SHALL return to STABLE and clear the counter, with dout unchanged and no pulse (glitch rejected).
REQ-016 In QUALIFY with s != dout and counter == STABLE_CNT-1, SHALL toggle dout, clear the counter and return to STABLE.
REQ-017 In QUALIFY with s != dout and counter < STABLE_CNT-1, SHALL increment the counter.
REQ-018 SHALL toggle dout on the edge where s has differed from dout for STABLE_CNT consecutive samples.
REQ-019 Latency: taking the first edge that captures the new din level as edge 1, dout SHALL change on edge SYNC_STAGES+STABLE_CNT.
REQ-020 rise and fall SHALL be registered and asserted for exactly the one cycle in which the new dout value first appears; they SHALL never be high together.
REQ-021 busy SHALL be high exactly while the FSM is in QUALIFY.
REQ-022 Counter width SHALL be clog2(STABLE_CNT+1) bits; the counter SHALL never exceed STABLE_CNT-1 and never wrap.
REQ-023 A din pulse shorter than STABLE_CNT cycles after synchronization SHALL produce no dout change and no pulse.
REQ-024 Back-to-back accepted transitions SHALL each be separated by at least STABLE_CNT cycles and each SHALL produce its own pulse.

Reset
REQ-025 While rst is high, all synchronizer flops and dout SHALL equal RESET_LEVEL; rise, fall, busy and the counter SHALL be 0; the FSM SHALL be in STABLE.
REQ-026 Reset asserted mid-QUALIFY SHALL abort qualification immediately, with no pulse.
REQ-027 Deasserting rst SHALL NOT produce a rise or fall pulse; if din differs from RESET_LEVEL, normal qualification SHALL follow.

Structure
REQ-028 FSM state encodings (STABLE=1'b0, QUALIFY=1'b1) SHALL live in the shared package uart_pkg, for reuse by the receiver.
REQ-029 The flop chain SHALL be a separate sub-module sync_chain (parameters STAGES and INIT; ports clk, rst, d, q), reusable for other asynchronous inputs.
REQ-030 The counter and FSM SHALL reside in debounce_sync; the block SHALL contain no latches and no combinational path from din to any output.

Verification (defaults: SYNC_STAGES=2, STABLE_CNT=16, RESET_LEVEL=1)
REQ-031 Reset, then din held at 1 for 50 cycles -> dout=1, rise/fall/busy stay 0 throughout.
REQ-032 din 1->0 held -> fall pulses for 1 cycle on edge 18 after capture, dout=0 from then on, busy high for 15 cycles before.
REQ-033 din low for 10 cycles, then high -> busy pulses, dout stays 1, no fall.
REQ-034 din 0->1 after settling low -> rise pulses once on edge 18, dout=1.
REQ-035 din low for 8 cycles, then rst asserted for 2 cycles -> dout=1 immediately, busy=0, no pulse on rst release; din still low -> fall on edge 18 after release.
REQ-036 STABLE_CNT=1 with din toggling every 3 cycles -> dout follows din delayed 3 edges, alternating rise/fall pulses.
